// File: rtl/led7seg_scan.sv
// led7seg_scan: time-multiplexed 7-segment scanner.
// Latches the parallel segment image once per frame, then walks the digits
// one slot at a time. Each slot begins with a short all-off blanking gap.
// Optional feature: define LED7SEG_BRIGHTNESS_EN to add the 4-bit
// 'brightness' input, which gates the segments inside each slot.
module led7seg_scan #(
   parameter int DIGITS       = 3,
   parameter int SCAN_DIV     = 4096,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [8*DIGITS-1:0] seg_data,
`ifdef LED7SEG_BRIGHTNESS_EN
   input  logic [3:0]          brightness,
`endif
   output logic [7:0]          led_seg_n,
   output logic [DIGITS-1:0]   led_dig_n,
   output logic                frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

   logic [CW-1:0]       cnt;
   logic [DW-1:0]       dig;
   logic [8*DIGITS-1:0] shadow;
   logic                slot_end;
   logic                frame_end;
   logic [7:0]          seg_nxt;
   logic [DIGITS-1:0]   dig_nxt;
`ifdef LED7SEG_BRIGHTNESS_EN
   logic [3:0]          bri;
`endif

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (dig == DIG_LAST);

   // Slot counter and digit index; the digit advances when a slot wraps.
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         dig <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow image reload at the very end of a frame, so a mid-frame write
   // to seg_data never tears the displayed picture.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow     <= '1;
         frame_tick <= 1'b0;
`ifdef LED7SEG_BRIGHTNESS_EN
         bri        <= 4'hF;
`endif
      end else begin
         frame_tick <= frame_end;
         if (frame_end) begin
            shadow <= seg_data;
`ifdef LED7SEG_BRIGHTNESS_EN
            bri    <= brightness;
`endif
         end
      end
   end

   // Drive decision from the current slot position and the shadow image.
   // NOTE: both outputs get an all-off default before any branch, so no
   // path leaves them unassigned and no latch is inferred.
   always_comb begin
      seg_nxt = '1;
      dig_nxt = '1;
      if (int'(cnt) >= BLANK_CYCLES) begin
         dig_nxt = ~(DIGITS'(1) << dig);
`ifdef LED7SEG_BRIGHTNESS_EN
         if (cnt[3:0] <= bri) begin
            seg_nxt = shadow[8*dig +: 8];
         end
`else
         seg_nxt = shadow[8*dig +: 8];
`endif
      end
   end

   // Registered output stage: one-hot-low strobes straight from a flop, so
   // two digits can never be low together, even transiently.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_seg_n <= '1;
         led_dig_n <= '1;
      end else begin
         led_seg_n <= seg_nxt;
         led_dig_n <= dig_nxt;
      end
   end

endmodule
